mp_sync_rx: RTL and testbench

//  Receiver bridging a two-phase (transition-signalled) bundled-data micropipeline

---
 rtl/mp_pkg.sv | 27 ++
 rtl/mp_sync_rx_sync_ff.sv | 32 +++
 rtl/mp_sync_rx.sv | 151 +++++++++++++++
 tb/tb_mp_sync_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// ---------------------------------------------------------------------------
// mp_pkg
// Shared definitions for the two-phase micropipeline receiver:
//   PH_IDLE / PH_ACTIVE  two-phase wire levels (PH_IDLE is the reset level)
//   SYNC_STAGES_DEF      default depth of the req synchronizer
//   clog2()              ceiling log2 usable in constant expressions
// ---------------------------------------------------------------------------
package mp_pkg;

  localparam logic PH_IDLE   = 1'b0;
  localparam logic PH_ACTIVE = 1'b1;

  localparam int SYNC_STAGES_DEF = 2;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mp_sync_rx_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for a single asynchronous level signal.
//   clk   in   sampling clock
//   rstn  in   asynchronous active-low reset, chain clears to PH_IDLE
//   d_i   in   asynchronous input level
//   q_o   out  synchronized level (last flop of the chain)
// ---------------------------------------------------------------------------
module sync_ff
  import mp_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= {STAGES{PH_IDLE}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mp_sync_rx.sv
// ---------------------------------------------------------------------------
// mp_sync_rx
// Receives tokens from a two-phase bundled-data micropipeline, buffers them
// in a DEPTH-entry FIFO and presents them on a valid/ready interface. One
// ack transition is returned upstream per accepted token.
//
// Ports:
//   clk        in   sampling clock
//   rstn       in   asynchronous active-low reset
//   req_in     in   two-phase request, each transition is one token
//   data_in    in   bundled data, stable while the token is unacknowledged
//   ack_out    out  two-phase acknowledge
//   out_valid  out  FIFO head valid
//   out_ready  in   consumer takes head when out_valid && out_ready
//   out_data   out  FIFO head data (0 while empty)
//   level      out  FIFO occupancy
//   proto_err  out  sticky protocol-violation flag (MP_SYNC_RX_ERR_EN only)
//
// Build option: define MP_SYNC_RX_ERR_EN to add proto_err, which sets when a
// second req transition arrives while a token is still unacknowledged.
// ---------------------------------------------------------------------------
module mp_sync_rx
  import mp_pkg::*;
#(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_in,
  input  logic [DW-1:0]          data_in,
  output logic                   ack_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
`ifdef MP_SYNC_RX_ERR_EN
  output logic [$clog2(DEPTH):0] level,
  output logic                   proto_err
`else
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          s;
  logic          pending;
  logic          push;
  logic          pop;

  logic          p_q,     p_d;
  logic          ack_q,   ack_d;
  logic [AW-1:0] wptr_q,  wptr_d;
  logic [AW-1:0] rptr_q,  rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] mem_q [DEPTH];

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (req_in),
    .q_o  (s)
  );

  // A token is outstanding whenever the synchronized req phase differs from
  // the phase we last acknowledged.
  assign pending = s ^ p_q;
  assign pop     = valid_q && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push    = pending && ((level_q < LW'(DEPTH)) || pop);

  always_comb begin
    p_d     = p_q;
    ack_d   = ack_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      p_d    = s;
      ack_d  = ~ack_q;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    valid_d = (level_d != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q     <= PH_IDLE;
      ack_q   <= PH_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      ack_q   <= ack_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  // Storage carries no reset; unread entries are masked on out_data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= data_in;
    end
  end

  assign ack_out   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = valid_q ? mem_q[rptr_q] : '0;
  assign level     = level_q;

`ifdef MP_SYNC_RX_ERR_EN
  // hold_q remembers that a token was waiting last cycle and was not taken;
  // a fresh edge on s on top of that means upstream did not wait for ack.
  logic s_prev_q;
  logic hold_q;
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_prev_q <= PH_IDLE;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_prev_q <= s;
      hold_q   <= pending && !push;
      if (hold_q && (s != s_prev_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign proto_err = err_q;
`endif

endmodule

// File: tb/tb_mp_sync_rx.sv
module tb_mp_sync_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          req_in    = 1'b0;
  logic [DW-1:0] data_in   = '0;
  logic          out_ready = 1'b0;
  logic          ack_out;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    level;
`ifdef MP_SYNC_RX_ERR_EN
  logic          proto_err;
`endif

  mp_sync_rx #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef MP_SYNC_RX_ERR_EN
    .level     (level),
    .proto_err (proto_err)
`else
    .level     (level)
`endif
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  int            acks     = 0;
  logic [DW-1:0] sb [$];
  bit            rnd_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected stream: every token accepted upstream must come out in order.
  initial begin
    logic [DW-1:0] exp;
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got %0h with nothing expected at %0t", out_data, $time);
        end else begin
          exp = sb.pop_front();
          check("pop_data", {24'd0, out_data}, {24'd0, exp});
        end
      end
    end
  end

  // Issue one token and wait (bounded) for its acknowledge.
  task automatic send(input logic [DW-1:0] d);
    data_in = d;
    req_in  = ~req_in;
    sb.push_back(d);
    for (int i = 0; i < 20 && ack_out !== req_in; i++) tick(1);
    check("ack_handshake", {31'd0, ack_out}, {31'd0, req_in});
    if (ack_out === req_in) acks++;
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic ack_b;
    int   acks_b;

    // Reset with junk on the inputs.
    rstn = 1'b0; req_in = 1'b1; data_in = 8'($urandom); out_ready = 1'b1;
    tick(2);
    check("rst_ack",   {31'd0, ack_out},   32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {29'd0, level},     32'd0);
    check("rst_data",  {24'd0, out_data},  32'd0);
`ifdef MP_SYNC_RX_ERR_EN
    check("rst_err",   {31'd0, proto_err}, 32'd0);
`endif
    req_in = 1'b0; out_ready = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(5);
    check("rel_ack",   {31'd0, ack_out}, 32'd0);
    check("rel_level", {29'd0, level},   32'd0);

    // Single token latency.
    data_in = 8'hA5; req_in = 1'b1; sb.push_back(8'hA5);
    tick(1);
    check("lat_ack_c1", {31'd0, ack_out}, 32'd0);
    tick(1);
    check("lat_ack_c2", {31'd0, ack_out}, 32'd0);
    tick(1);
    check("lat_ack_c3",   {31'd0, ack_out},   32'd1);
    check("lat_valid_c3", {31'd0, out_valid}, 32'd1);
    check("lat_data_c3",  {24'd0, out_data},  32'hA5);
    check("lat_level_c3", {29'd0, level},     32'd1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("single_drained", {29'd0, level}, 32'd0);

    // Fill to capacity, fifth token stalls until a pop frees a slot.
    for (int i = 1; i <= 4; i++) send(8'(i));
    check("fill_level", {29'd0, level}, 32'd4);
    ack_b = ack_out;
    data_in = 8'h05; req_in = ~req_in; sb.push_back(8'h05);
    tick(6);
    check("stall_ack",   {31'd0, ack_out}, {31'd0, ack_b});
    check("stall_level", {29'd0, level},   32'd4);
    check("stall_head",  {24'd0, out_data}, 32'h01);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("swap_level", {29'd0, level},   32'd4);
    check("swap_ack",   {31'd0, ack_out}, {31'd0, ~ack_b});
    out_ready = 1'b1;
    tick(6);
    out_ready = 1'b0;
    check("fill_drained", {29'd0, level}, 32'd0);
    check("fill_sb_empty", sb.size(), 32'd0);

    // Streaming, pointers wrap several times.
    out_ready = 1'b1;
    acks_b = acks;
    for (int i = 0; i < 16; i++) send(8'($urandom));
    tick(5);
    check("stream_acks",  acks - acks_b, 32'd16);
    check("stream_empty", sb.size(),     32'd0);
    check("stream_level", {29'd0, level}, 32'd0);

    // Random backpressure with random token spacing.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          out_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join_none
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom));
      tick($urandom_range(0, 3));
    end
    rnd_on = 1'b0;
    tick(2);
    out_ready = 1'b1;
    tick(12);
    check("rand_empty", sb.size(),      32'd0);
    check("rand_level", {29'd0, level}, 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset with buffered and in-flight tokens.
    for (int i = 0; i < 3; i++) send(8'($urandom));
    check("mid_level", {29'd0, level}, 32'd3);
    data_in = 8'h77; req_in = ~req_in;
    tick(1);
    #2 rstn = 1'b0;
    #1;
    check("arst_ack",   {31'd0, ack_out},   32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_level", {29'd0, level},     32'd0);
    check("arst_data",  {24'd0, out_data},  32'd0);
    sb.delete();
    req_in = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(8);
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_level", {29'd0, level},     32'd0);
    check("post_ack",   {31'd0, ack_out},   32'd0);

    // Protocol violation: two req edges without an ack while full.
    for (int i = 0; i < 4; i++) send(8'($urandom));
    ack_b = ack_out;
    data_in = 8'hE1; req_in = ~req_in;
    tick(4);
    data_in = 8'hE2; req_in = ~req_in;
    tick(4);
    check("viol_ack",   {31'd0, ack_out}, {31'd0, ack_b});
    check("viol_level", {29'd0, level},   32'd4);
`ifdef MP_SYNC_RX_ERR_EN
    check("viol_err", {31'd0, proto_err}, 32'd1);
`endif
    out_ready = 1'b1;
    tick(8);
    out_ready = 1'b0;
    check("viol_empty", sb.size(),      32'd0);
    check("viol_level_after", {29'd0, level}, 32'd0);
`ifdef MP_SYNC_RX_ERR_EN
    check("viol_err_sticky", {31'd0, proto_err}, 32'd1);
`endif
    rstn = 1'b0;
    tick(2);
`ifdef MP_SYNC_RX_ERR_EN
    check("viol_err_cleared", {31'd0, proto_err}, 32'd0);
`endif
    check("final_ack", {31'd0, ack_out}, 32'd0);
    rstn = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
